// File: rtl/shift_reg_ctrl_pkg.sv
// rtl/shift_reg_ctrl_pkg.sv - shift register opcodes and sequencer state codes
// Shared by the sequencer, the shift register and any future receiver path.
package shift_reg_ctrl_pkg;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_SHL  = 2'b01;
  localparam logic [1:0] OP_SHR  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

  function automatic logic [1:0] shift_op(input logic toward_msb);
    return toward_msb ? OP_SHL : OP_SHR;
  endfunction

endpackage

// File: rtl/shift_reg_ctrl_counter.sv
// rtl/shift_reg_ctrl_counter.sv - up counter with enable, sync clear and terminal-count flag
// Clear wins over enable; tc_o compares the current count against last_i.
module mod_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] last_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tc_o = (cnt_q == last_i);

endmodule

// File: rtl/shift_reg_ctrl.sv
// rtl/shift_reg_ctrl.sv - word sequencer driving the universal shift register Pin/Op inputs
// One LOAD cycle, WIDTH tick-paced shifts, then an optional fixed idle gap.
module shift_reg_ctrl
  import shift_reg_ctrl_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             s_valid,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_dir,
  output logic             s_ready,
  input  logic             tick,
  output logic [WIDTH-1:0] Pin,
  output logic [1:0]       Op,
  output logic             bit_valid,
  output logic             busy,
  output logic             frame_done
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
  localparam logic [3:0]    GAP_LAST = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_e           state_q;
  logic [WIDTH-1:0] pin_q;
  logic             dir_q;
  logic             rdy_en_q;
  logic             bit_tc;
  logic             gap_tc;
  logic             accept;
  logic             last_tick;

  assign accept    = s_valid & s_ready;
  assign last_tick = (state_q == ST_SHIFT) & tick & bit_tc;

  mod_counter #(.W(CW)) u_bit_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (state_q == ST_LOAD),
    .en_i    ((state_q == ST_SHIFT) & tick),
    .last_i  (BIT_LAST),
    .tc_o    (bit_tc)
  );

  // Held at zero outside GAP so every gap starts from a clean count.
  mod_counter #(.W(4)) u_gap_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (state_q != ST_GAP),
    .en_i    (state_q == ST_GAP),
    .last_i  (GAP_LAST),
    .tc_o    (gap_tc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      pin_q    <= '0;
      dir_q    <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            pin_q   <= s_data;
            dir_q   <= s_dir;
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: state_q <= ST_SHIFT;
        ST_SHIFT: begin
          if (last_tick) begin
            state_q <= (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
          end
        end
        ST_GAP: begin
          if (gap_tc) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    Op = OP_HOLD;
    case (state_q)
      ST_LOAD:  Op = OP_LOAD;
      ST_SHIFT: Op = tick ? shift_op(dir_q) : OP_HOLD;
      default:  Op = OP_HOLD;
    endcase
  end

  assign s_ready    = rdy_en_q & (state_q == ST_IDLE);
  assign bit_valid  = (state_q == ST_SHIFT);
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = last_tick;
  assign Pin        = pin_q;

endmodule
